// File: rtl/time_edit_pkg.sv
// Shared types and limits for the RTC time-setting controller.
package time_edit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT
  } state_e;

  localparam logic [1:0] FIELD_HOUR = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_SEC  = 2'd2;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

endpackage

// File: rtl/bcd_field_step.sv
// Combinational packed-BCD +/-1 with wrap between 00 and max_i.
module bcd_field_step (
  input  logic [7:0] val_i,
  input  logic [7:0] max_i,
  input  logic       up_i,
  output logic [7:0] val_o
);

  logic [3:0] hi;
  logic [3:0] lo;

  assign hi = val_i[7:4];
  assign lo = val_i[3:0];

  always_comb begin
    val_o = val_i;
    if (up_i) begin
      // out-of-range loads also land on 00
      if (val_i >= max_i || lo > 4'd9) val_o = 8'h00;
      else if (lo == 4'd9)             val_o = {hi + 4'd1, 4'd0};
      else                             val_o = {hi, lo + 4'd1};
    end else begin
      if (val_i == 8'h00 || val_i > max_i || lo > 4'd9) val_o = max_i;
      else if (lo == 4'd0) val_o = {hi - 4'd1, 4'd9};
      else                 val_o = {hi, lo - 4'd1};
    end
  end

endmodule

// File: rtl/time_edit_controller.sv
// User time-setting FSM: edit buffer, field cursor, RTC write handshake.
// Optional EDIT_TIMEOUT_EN abandons EDIT after TIMEOUT_CYCLES idle cycles.
module time_edit_controller
  import time_edit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EditPulse,
  input  logic       UpPulse,
  input  logic       DownPulse,
  input  logic       LeftPulse,
  input  logic       RightPulse,
  input  logic [7:0] HourIn,
  input  logic [7:0] MinIn,
  input  logic [7:0] SecIn,
  input  logic       WriteAck,
  output logic [7:0] HourOut,
  output logic [7:0] MinOut,
  output logic [7:0] SecOut,
  output logic [1:0] Cursor,
  output logic       Editing,
  output logic       WriteReq
);

  state_e     state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic [1:0] cursor_q, cursor_d;
  logic       editing_q, editing_d;
  logic       write_req_q, write_req_d;

  logic [7:0] fld_cur;
  logic [7:0] fld_max;
  logic [7:0] fld_nxt;

`ifdef EDIT_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    unique case (cursor_q)
      FIELD_MIN: begin
        fld_cur = min_q;
        fld_max = MINSEC_MAX;
      end
      FIELD_SEC: begin
        fld_cur = sec_q;
        fld_max = MINSEC_MAX;
      end
      default: begin
        fld_cur = hour_q;
        fld_max = HOUR_MAX;
      end
    endcase
  end

  bcd_field_step u_step (
    .val_i (fld_cur),
    .max_i (fld_max),
    .up_i  (UpPulse),
    .val_o (fld_nxt)
  );

  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    cursor_d = cursor_q;
`ifdef EDIT_TIMEOUT_EN
    idle_cnt_d = '0;
`endif
    unique case (state_q)
      IDLE: begin
        hour_d = HourIn;
        min_d  = MinIn;
        sec_d  = SecIn;
        if (EditPulse) begin
          state_d  = EDIT;
          cursor_d = FIELD_HOUR;
        end
      end
      EDIT: begin
        priority case (1'b1)
          EditPulse: state_d = COMMIT;
          UpPulse, DownPulse: begin
            unique case (cursor_q)
              FIELD_MIN: min_d  = fld_nxt;
              FIELD_SEC: sec_d  = fld_nxt;
              default:   hour_d = fld_nxt;
            endcase
          end
          LeftPulse:
            cursor_d = (cursor_q == FIELD_HOUR) ? FIELD_SEC
                                                : cursor_q - 2'd1;
          RightPulse:
            cursor_d = (cursor_q == FIELD_SEC) ? FIELD_HOUR
                                               : cursor_q + 2'd1;
          default: begin
`ifdef EDIT_TIMEOUT_EN
            if (idle_cnt_q == TIMEOUT_CYCLES - 1) state_d = IDLE;
            else idle_cnt_d = idle_cnt_q + 32'd1;
`endif
          end
        endcase
      end
      COMMIT: begin
        if (WriteAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    editing_d   = (state_d != IDLE);
    write_req_d = (state_d == COMMIT);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      cursor_q    <= FIELD_HOUR;
      editing_q   <= 1'b0;
      write_req_q <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      cursor_q    <= cursor_d;
      editing_q   <= editing_d;
      write_req_q <= write_req_d;
`ifdef EDIT_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign HourOut  = hour_q;
  assign MinOut   = min_q;
  assign SecOut   = sec_q;
  assign Cursor   = cursor_q;
  assign Editing  = editing_q;
  assign WriteReq = write_req_q;

endmodule

// File: tb/tb_time_edit_controller.sv
// Directed bench for time_edit_controller with a decimal reference model.
module tb_time_edit_controller;

  localparam int TO = 20;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       EditPulse = 1'b0;
  logic       UpPulse = 1'b0;
  logic       DownPulse = 1'b0;
  logic       LeftPulse = 1'b0;
  logic       RightPulse = 1'b0;
  logic [7:0] HourIn = 8'h12;
  logic [7:0] MinIn = 8'h34;
  logic [7:0] SecIn = 8'h56;
  logic       WriteAck = 1'b0;
  logic [7:0] HourOut, MinOut, SecOut;
  logic [1:0] Cursor;
  logic       Editing, WriteReq;

  int checks = 0;
  int errors = 0;

  time_edit_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .EditPulse(EditPulse), .UpPulse(UpPulse), .DownPulse(DownPulse),
    .LeftPulse(LeftPulse), .RightPulse(RightPulse),
    .HourIn(HourIn), .MinIn(MinIn), .SecIn(SecIn),
    .WriteAck(WriteAck),
    .HourOut(HourOut), .MinOut(MinOut), .SecOut(SecOut),
    .Cursor(Cursor), .Editing(Editing), .WriteReq(WriteReq)
  );

  always #5 CLK = ~CLK;

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fields kept as decimal integers, mode 0/1/2 = idle/edit/commit
  int mh = 0, mm = 0, ms = 0, mcur = 0, mmode = 0, quiet = 0;

  task automatic bump(input int d);
    if (mcur == 0) mh = (mh + 24 + d) % 24;
    else if (mcur == 1) mm = (mm + 60 + d) % 60;
    else ms = (ms + 60 + d) % 60;
  endtask

  always @(posedge CLK) begin
    if (!RESET) begin
      mh = 0; mm = 0; ms = 0; mcur = 0; mmode = 0; quiet = 0;
    end else if (mmode == 0) begin
      mh = dec(HourIn); mm = dec(MinIn); ms = dec(SecIn);
      if (EditPulse) begin mmode = 1; mcur = 0; quiet = 0; end
    end else if (mmode == 1) begin
      if (EditPulse) mmode = 2;
      else if (UpPulse) bump(1);
      else if (DownPulse) bump(-1);
      else if (LeftPulse) mcur = (mcur + 2) % 3;
      else if (RightPulse) mcur = (mcur + 1) % 3;
`ifdef EDIT_TIMEOUT_EN
      if (EditPulse | UpPulse | DownPulse | LeftPulse | RightPulse)
        quiet = 0;
      else begin
        quiet++;
        if (quiet == TO) mmode = 0;
      end
`endif
    end else begin
      if (WriteAck) mmode = 0;
    end
  end

  always @(posedge CLK) begin
    #1;
    chk("model_hour", int'(HourOut), int'(bcd(mh)));
    chk("model_min", int'(MinOut), int'(bcd(mm)));
    chk("model_sec", int'(SecOut), int'(bcd(ms)));
    chk("model_cursor", int'(Cursor), mcur);
    chk("model_editing", int'(Editing), int'(mmode != 0));
    chk("model_writereq", int'(WriteReq), int'(mmode == 2));
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [7:0] sh, sm, ss;
    logic [1:0] sc;

    cyc(2);
    chk("rst_hour", int'(HourOut), 'h00);
    chk("rst_editing", int'(Editing), 0);
    chk("rst_writereq", int'(WriteReq), 0);
    RESET = 1'b1;
    cyc();
    chk("track_hour", int'(HourOut), 'h12);
    chk("track_editing", int'(Editing), 0);

    HourIn = 8'h23; MinIn = 8'h59; SecIn = 8'h58;
    cyc();
    EditPulse = 1'b1; cyc(); EditPulse = 1'b0;
    chk("enter_editing", int'(Editing), 1);
    chk("enter_hour", int'(HourOut), 'h23);
    HourIn = 8'h05;
    UpPulse = 1'b1; cyc(); UpPulse = 1'b0;
    chk("up_hour_wrap", int'(HourOut), 'h00);
    chk("up_min_same", int'(MinOut), 'h59);
    chk("up_cursor", int'(Cursor), 0);

    repeat (2) begin RightPulse = 1'b1; cyc(); RightPulse = 1'b0; end
    chk("right2_cursor", int'(Cursor), 2);
    repeat (2) begin UpPulse = 1'b1; cyc(); UpPulse = 1'b0; end
    chk("sec_to_00", int'(SecOut), 'h00);
    DownPulse = 1'b1; cyc(); DownPulse = 1'b0;
    chk("down_sec_wrap", int'(SecOut), 'h59);
    repeat (3) begin LeftPulse = 1'b1; cyc(); LeftPulse = 1'b0; end
    chk("left3_cursor", int'(Cursor), 2);

    LeftPulse = 1'b1; cyc(); LeftPulse = 1'b0;
    repeat (10) begin UpPulse = 1'b1; cyc(); UpPulse = 1'b0; end
    chk("min_09", int'(MinOut), 'h09);
    UpPulse = 1'b1; RightPulse = 1'b1; cyc();
    UpPulse = 1'b0; RightPulse = 1'b0;
    chk("prio_min_10", int'(MinOut), 'h10);
    chk("prio_cursor", int'(Cursor), 1);
    DownPulse = 1'b1; LeftPulse = 1'b1; cyc();
    DownPulse = 1'b0; LeftPulse = 1'b0;
    chk("down_min_09", int'(MinOut), 'h09);
    chk("down_prio_cursor", int'(Cursor), 1);

    EditPulse = 1'b1; UpPulse = 1'b1; cyc();
    EditPulse = 1'b0; UpPulse = 1'b0;
    chk("commit_min_held", int'(MinOut), 'h09);
    sh = HourOut; sm = MinOut; ss = SecOut; sc = Cursor;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (!WriteReq) break;
      cnt++;
      if (HourOut != sh || MinOut != sm || SecOut != ss || Cursor != sc)
        chk("commit_stable", {HourOut, MinOut, SecOut, 6'(Cursor)},
            {sh, sm, ss, 6'(sc)});
      UpPulse = 1'(i % 2);
      RightPulse = 1'(1 - i % 2);
      WriteAck = 1'(i >= 5);
      cyc();
    end
    UpPulse = 1'b0; RightPulse = 1'b0; WriteAck = 1'b0;
    chk("commit_len6", cnt, 6);
    chk("commit_done_editing", int'(Editing), 0);
    HourIn = 8'h07;
    cyc();
    chk("retrack_hour", int'(HourOut), 'h07);

    WriteAck = 1'b1;
    EditPulse = 1'b1; cyc(2); EditPulse = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (!WriteReq) break;
      cnt++;
      cyc();
    end
    WriteAck = 1'b0;
    chk("preack_len1", cnt, 1);

    cyc();
    EditPulse = 1'b1; cyc(2); EditPulse = 1'b0;
    chk("abort_req_hi", int'(WriteReq), 1);
    RESET = 1'b0; cyc(); RESET = 1'b1;
    chk("abort_req_lo", int'(WriteReq), 0);
    chk("abort_editing", int'(Editing), 0);
    cyc(2);

`ifdef EDIT_TIMEOUT_EN
    EditPulse = 1'b1; cyc(); EditPulse = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!Editing) break;
      if (WriteReq) chk("to_no_write", 1, 0);
      cnt++;
      cyc();
    end
    chk("timeout_20", cnt, TO);
    cyc();
    EditPulse = 1'b1; cyc(); EditPulse = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!Editing) break;
      if (WriteReq) chk("to_no_write2", 1, 0);
      cnt++;
      RightPulse = 1'(i == 9);
      cyc();
    end
    RightPulse = 1'b0;
    chk("timeout_30", cnt, 30);
`else
    EditPulse = 1'b1; cyc(); EditPulse = 1'b0;
    cyc(40);
    chk("edit_persists", int'(Editing), 1);
    WriteAck = 1'b1;
    EditPulse = 1'b1; cyc(); EditPulse = 1'b0;
    cyc();
    WriteAck = 1'b0;
    chk("persist_exit", int'(Editing), 0);
`endif

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_edit_controller.md
# time_edit_controller

Consumes the single-cycle pulses produced by the push-button debouncer/one-shot stage and runs the user time-setting sequence for the RTC. It holds an editable BCD copy of hours/minutes/seconds, moves a field cursor, increments or decrements the selected field with wrap-around, and commits the result to the RTC interface through a request/acknowledge handshake. It sits between the button debouncers and the RTC write port, and also feeds the display path.

## Interface
- TIMEOUT_CYCLES, 500_000_000: inactivity limit in EDIT before abandoning; only used with EDIT_TIMEOUT_EN.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- EditPulse  in  1  one-shot; enters EDIT from IDLE; commits from EDIT.
- UpPulse, DownPulse  in  1 each  one-shot; +1 / −1 on the selected field.
- LeftPulse, RightPulse  in  1 each  one-shot; move the cursor.
- HourIn, MinIn, SecIn  in  8 each  live RTC time, packed BCD.
- WriteAck  in  1  RTC accepted the write; level, sampled only in COMMIT.
- HourOut, MinOut, SecOut  out  8 each  edit buffer, packed BCD, registered.
- Cursor  out  2  selected field: 0 = hour, 1 = min, 2 = sec; 3 is never produced.
- Editing  out  1  high in EDIT and COMMIT.
- WriteReq  out  1  write request to the RTC; holds the buffer stable while high.

## Operation
- States: IDLE, EDIT, COMMIT.
- IDLE: every cycle, the buffers register HourIn/MinIn/SecIn. EditPulse → EDIT and Cursor = 0. All other pulses are ignored.
- EDIT: the buffers freeze at the values loaded on the entry edge. Only one action executes per cycle, chosen by priority Edit > Up > Down > Left > Right. Lower-priority pulses in the same cycle are dropped.
- EditPulse in EDIT → COMMIT.
- Up on hour: 00..23, and 23 → 00. Up on min/sec: 00..59, and 59 → 00. BCD-correct: 09 → 10 and 19 → 20.
- Down is the mirror: 00 → 23 for hour, 00 → 59 for min/sec, and 10 → 09.
- Right: cursor 0 → 1 → 2 → 0. Left: cursor 0 → 2 → 1 → 0.
- COMMIT: WriteReq = 1 and the buffers are held. WriteAck sampled high → IDLE. All button pulses are ignored.
- In-range BCD inputs are assumed. Out-of-range field values loaded from the inputs wrap to 00 on Up.

## Timing
- Reset (RESET = 0 at an edge): state IDLE; HourOut = MinOut = SecOut = 8'h00; Cursor = 0; Editing = 0; WriteReq = 0.
- After reset, the outputs track the inputs with 1-cycle latency.
- A pulse sampled at edge n gives its effect on the outputs after edge n (1-cycle latency).
- EditPulse at edge n in IDLE: Editing = 1 from n. The buffer holds the inputs sampled at n.
- EditPulse at edge n in EDIT: WriteReq and Editing high from n.
- WriteAck sampled high at edge m: WriteReq = 0 and Editing = 0 from m. Buffer tracking resumes at m+1.
- WriteAck already high when COMMIT is entered: COMMIT lasts exactly 1 cycle.
- RESET low during COMMIT: WriteReq drops at that edge and no retry is made. The RTC side must tolerate an abandoned request.

## Configuration
- EDIT_TIMEOUT_EN defined:
  - A 32-bit inactivity counter runs in EDIT. It clears on entry and on any accepted pulse.
  - When it reaches TIMEOUT_CYCLES−1, the next edge → IDLE with no write, Editing = 0, and buffer tracking resumes.
  - The counter is frozen and cleared in COMMIT and IDLE.
- EDIT_TIMEOUT_EN undefined: no counter; EDIT persists until EditPulse or reset.

## Structure
- Package time_edit_pkg holds:
  - the state enum (IDLE/EDIT/COMMIT);
  - the cursor constants FIELD_HOUR/FIELD_MIN/FIELD_SEC;
  - the BCD limits HOUR_MAX = 8'h23 and MINSEC_MAX = 8'h59.
- Sub-module bcd_field_step: combinational BCD ±1 with a max-value input and wrap to/from 00. It is instantiated once and muxed by Cursor.

## Test plan
- Reset: RESET low for 2 cycles with HourIn = 8'h12 → all outputs 0. One cycle after release, HourOut = 8'h12, Editing = 0.
- Enter and increment: time 23:59:58, EditPulse, then UpPulse → HourOut = 8'h00, MinOut = 8'h59 unchanged, Cursor = 0.
- Cursor and decrement: in EDIT, RightPulse ×2 then DownPulse on SecOut = 8'h00 → Cursor = 2, SecOut = 8'h59. LeftPulse ×3 → Cursor = 2.
- Priority: UpPulse and RightPulse in the same cycle with MinOut = 8'h09 and Cursor = 1 → MinOut = 8'h10, Cursor stays 1.
- Commit handshake: EditPulse in EDIT, WriteAck held low 5 cycles then high → WriteReq high exactly 6 cycles, buffer stable throughout, pulses ignored, then IDLE. Also check WriteAck pre-asserted → WriteReq high for 1 cycle.
- Timeout (EDIT_TIMEOUT_EN, TIMEOUT_CYCLES = 20): enter EDIT, no pulses → Editing falls after 20 cycles and WriteReq never asserts. A pulse at cycle 10 extends this to cycle 30.
